lapido_run_monitor: RTL
=======================

Name: lapido_run_monitor

Overview:
- Synthesizable run-control monitor for the LAPI DOpaCA LAMBA core; sits beside lapido_top and observes the ID/IF stages.
- Detects the halt idiom: a taken jump in ID whose target equals the current IF PC minus one, i.e. a jump-to-self.
- Drains the pipeline for a parametrised number of cycles, then asserts done.
- Counts cycles and issued instructions, and runs an optional watchdog so benches and FPGA builds share one stop mechanism.

Parameters:
- PC_WIDTH, 32, width of the PC and jump-address buses.
- CNT_WIDTH, 32, width of the cycle and instruction counters.
- DRAIN_CYCLES, 3, cycles spent in DRAIN before done; legal range 1..255.
- MAX_CYCLES, 0, watchdog limit in RUN cycles; 0 disables the watchdog.
- HIST_DEPTH, 8, jump-history depth; power of two; used only with LAPIDO_MON_HIST_EN.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous restart; returns the block to RUN and zeroes counters.
- id_valid  in  1  ID stage holds a valid, non-bubble instruction this cycle.
- id_stall  in  1  ID is stalled; the instruction is not counted.
- id_is_jump  in  1  the instruction in ID is a taken jump.
- id_jump_addr  in  PC_WIDTH  jump target.
- if_pc  in  PC_WIDTH  current IF PC.
- halted  out  1  halt has been detected (high in DRAIN and DONE).
- done  out  1  drain complete; sticky until clear or reset.
- timeout  out  1  watchdog expired; sticky until clear or reset.
- state  out  2  encoded FSM state.
- cycle_count  out  CNT_WIDTH  clock cycles spent in RUN.
- instr_count  out  CNT_WIDTH  instructions issued while in RUN.
- halt_pc  out  PC_WIDTH  id_jump_addr captured at detection.

Behaviour:
- Reset (rst low, asynchronous):
  - state=RUN.
  - All counters, halt_pc, halted, done and timeout are 0.
- State encoding: RUN=0, DRAIN=1, DONE=2, TIMEOUT=3.
- Halt condition: id_valid & id_is_jump & ~id_stall & (id_jump_addr == if_pc - 1).
  - The subtraction is modulo 2^PC_WIDTH, so if_pc=0 matches id_jump_addr = all ones.
- RUN:
  - cycle_count increments every cycle.
  - instr_count increments when id_valid & ~id_stall.
  - On the halt condition, the next state is DRAIN, halt_pc is captured and the drain counter is loaded with DRAIN_CYCLES-1.
  - The detecting instruction is counted.
- DRAIN:
  - Counters are frozen.
  - The drain counter decrements each cycle; at 0 the next state is DONE.
  - done rises exactly DRAIN_CYCLES cycles after the detection edge.
  - Further halt conditions are ignored.
- DONE: terminal; all outputs hold.
- Watchdog (MAX_CYCLES>0):
  - In RUN, when cycle_count == MAX_CYCLES-1 and no halt condition is present, the next state is TIMEOUT and timeout=1.
  - If a halt condition and the watchdog limit occur in the same cycle, halt wins and the state goes to DRAIN.
- TIMEOUT: terminal; counters frozen.
- Counter saturation: counters saturate at all ones and never wrap.
- clear: has priority over every transition; next state is RUN and all registers are reset, exactly as rst.
- rst asserted mid-DRAIN aborts the drain immediately.
- Outputs are registered; no combinational input-to-output paths.

Optional Feature:
- Macro: LAPIDO_MON_HIST_EN.
- Defined:
  - A circular buffer of the last HIST_DEPTH taken-jump targets is captured in RUN (id_valid & id_is_jump & ~id_stall).
  - The write pointer wraps modulo HIST_DEPTH, and the oldest entry is overwritten.
  - Added ports:
    - hist_idx  in  log2(HIST_DEPTH): read index; 0 = newest.
    - hist_data  out  PC_WIDTH: combinational read.
    - hist_count  out  log2(HIST_DEPTH)+1: entries captured, saturating at HIST_DEPTH.
  - An index at or beyond hist_count reads 0.
  - The buffer is cleared by rst and by clear.
- Undefined: the ports and buffer are absent; all other behaviour is identical.

Decomposition:
- Add to lapido_defs.v:
  - state codes MON_RUN, MON_DRAIN, MON_DONE, MON_TIMEOUT;
  - default widths;
  - the macro guard.
- One natural sub-module: lapido_jump_hist, the circular history buffer, instantiated only under LAPIDO_MON_HIST_EN.
- The counters and FSM stay in the top module.

Test Plan:
1. Reset, then 10 valid unstalled non-jump instructions, then a halt with if_pc=0x40 and id_jump_addr=0x3F -> instr_count=11, halt_pc=0x3F, done asserted 3 cycles after detection, cycle_count frozen.
2. Halt condition presented with id_stall=1 -> ignored, state stays RUN; the same condition with the stall released -> DRAIN.
3. MAX_CYCLES=20 with no halt -> timeout=1 and state=3 with cycle_count=19; a halt on that same cycle instead -> DRAIN, timeout=0.
4. if_pc=0, id_jump_addr=0xFFFFFFFF, taken jump -> halt detected (wrap-around case).
5. rst asserted mid-DRAIN -> all outputs zero immediately; clear in DONE -> RUN with zeroed counters on the next edge.
6. With LAPIDO_MON_HIST_EN and HIST_DEPTH=4, six jumps to 0x10, 0x20 ... 0x60 -> hist_count=4, hist_idx 0..3 read 0x60, 0x50, 0x40, 0x30.

Source files
------------

// File: rtl/lapido_run_monitor_pkg.sv
// Shared definitions for the LAPI DOpaCA run-control monitor: FSM state codes and default widths.
// The optional jump-history buffer is enabled with the LAPIDO_MON_HIST_EN macro.
package lapido_run_monitor_pkg;

  typedef enum logic [1:0] {
    MON_RUN     = 2'd0,
    MON_DRAIN   = 2'd1,
    MON_DONE    = 2'd2,
    MON_TIMEOUT = 2'd3
  } mon_state_e;

  localparam int DEF_PC_WIDTH     = 32;
  localparam int DEF_CNT_WIDTH    = 32;
  localparam int DEF_DRAIN_CYCLES = 3;
  localparam int DEF_MAX_CYCLES   = 0;
  localparam int DEF_HIST_DEPTH   = 8;

  // Wide enough for the largest legal drain length (255).
  localparam int DRAIN_CNT_W = 8;

endpackage

// File: rtl/lapido_jump_hist.sv
// Circular history of the most recent taken-jump targets; index 0 reads the newest entry.
// Compiled only when LAPIDO_MON_HIST_EN is defined.
`ifdef LAPIDO_MON_HIST_EN
module lapido_jump_hist #(
  parameter int PC_WIDTH   = 32,
  parameter int HIST_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          wr_en,
  input  logic [PC_WIDTH-1:0]           wr_data,
  input  logic [$clog2(HIST_DEPTH)-1:0] rd_idx,
  output logic [PC_WIDTH-1:0]           rd_data,
  output logic [$clog2(HIST_DEPTH):0]   count
);

  localparam int PTR_W = $clog2(HIST_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(HIST_DEPTH);

  logic [PC_WIDTH-1:0] mem [HIST_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
      wr_ptr      <= wr_ptr + PTR_ONE;
      if (count != CNT_FULL) count <= count + CNT_ONE;
    end
  end

  // The newest entry sits one slot behind the write pointer; walk backwards from there.
  assign rd_ptr  = wr_ptr - PTR_ONE - rd_idx;
  assign rd_data = ({1'b0, rd_idx} < count) ? mem[rd_ptr] : '0;

endmodule
`endif

// File: rtl/lapido_run_monitor.sv
// Run-control monitor beside lapido_top: detects the jump-to-self halt idiom, drains, counts, watchdog.
// Defining LAPIDO_MON_HIST_EN adds the hist_idx/hist_data/hist_count jump-history ports.
module lapido_run_monitor
  import lapido_run_monitor_pkg::*;
#(
  parameter int PC_WIDTH     = DEF_PC_WIDTH,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int MAX_CYCLES   = DEF_MAX_CYCLES,
  parameter int HIST_DEPTH   = DEF_HIST_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clear,
  input  logic                          id_valid,
  input  logic                          id_stall,
  input  logic                          id_is_jump,
  input  logic [PC_WIDTH-1:0]           id_jump_addr,
  input  logic [PC_WIDTH-1:0]           if_pc,
  output logic                          halted,
  output logic                          done,
  output logic                          timeout,
  output logic [1:0]                    state,
  output logic [CNT_WIDTH-1:0]          cycle_count,
  output logic [CNT_WIDTH-1:0]          instr_count,
`ifdef LAPIDO_MON_HIST_EN
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
  output logic [PC_WIDTH-1:0]           hist_data,
  output logic [$clog2(HIST_DEPTH):0]   hist_count,
`endif
  output logic [PC_WIDTH-1:0]           halt_pc
);

  localparam logic [PC_WIDTH-1:0]    PC_ONE     = PC_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]   CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_ONE  = DRAIN_CNT_W'(1);
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES - 1);
  localparam bit                     WD_EN      = (MAX_CYCLES > 0);
  localparam logic [CNT_WIDTH-1:0]   WD_LAST    = WD_EN ? CNT_WIDTH'(MAX_CYCLES - 1) : '0;

  if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 255) begin : g_bad_drain
    $error("lapido_run_monitor: DRAIN_CYCLES must lie in 1..255");
  end
  if (HIST_DEPTH < 2 || (HIST_DEPTH & (HIST_DEPTH - 1)) != 0) begin : g_bad_hist
    $error("lapido_run_monitor: HIST_DEPTH must be a power of two >= 2");
  end

  mon_state_e             state_q;
  logic [DRAIN_CNT_W-1:0] drain_cnt;
  logic                   issue;
  logic                   jump_taken;
  logic                   halt_cond;
  logic                   wd_hit;

  assign issue      = id_valid & ~id_stall;
  assign jump_taken = issue & id_is_jump;
  // Jump-to-self: IF has already moved one past the jump, so the target is if_pc-1 (mod 2^PC_WIDTH).
  assign halt_cond  = jump_taken & (id_jump_addr == (if_pc - PC_ONE));
  assign wd_hit     = WD_EN & (cycle_count == WD_LAST) & ~halt_cond;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= MON_RUN;
      drain_cnt   <= '0;
      cycle_count <= '0;
      instr_count <= '0;
      halt_pc     <= '0;
      halted      <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
    end else if (clear) begin
      state_q     <= MON_RUN;
      drain_cnt   <= '0;
      cycle_count <= '0;
      instr_count <= '0;
      halt_pc     <= '0;
      halted      <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      case (state_q)
        MON_RUN: begin
          if (issue && instr_count != '1) instr_count <= instr_count + CNT_ONE;
          // The expiring cycle is not tallied, so cycle_count reads MAX_CYCLES-1 in TIMEOUT.
          if (wd_hit) begin
            state_q <= MON_TIMEOUT;
            timeout <= 1'b1;
          end else begin
            if (cycle_count != '1) cycle_count <= cycle_count + CNT_ONE;
            if (halt_cond) begin
              state_q   <= MON_DRAIN;
              halted    <= 1'b1;
              halt_pc   <= id_jump_addr;
              drain_cnt <= DRAIN_LOAD;
            end
          end
        end
        MON_DRAIN: begin
          if (drain_cnt == '0) begin
            state_q <= MON_DONE;
            done    <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - DRAIN_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign state = state_q;

`ifdef LAPIDO_MON_HIST_EN
  logic hist_wr;
  assign hist_wr = (state_q == MON_RUN) & jump_taken;

  lapido_jump_hist #(
    .PC_WIDTH  (PC_WIDTH),
    .HIST_DEPTH(HIST_DEPTH)
  ) u_hist (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .wr_en  (hist_wr),
    .wr_data(id_jump_addr),
    .rd_idx (hist_idx),
    .rd_data(hist_data),
    .count  (hist_count)
  );
`endif

endmodule
